// File: rtl/trace_ram_arbiter_if.sv
// Trace RAM arbiter bus: video timing, capture stream, trace RAM port and pixel output.
// master = environment (sync/ADC/RAM side), slave = the arbiter.
interface trace_ram_arbiter_if #(
  parameter int DATA_W = 12
);
  logic              vidstate;
  logic [9:0]        h;
  logic              frame_start;
  logic              arm;
  logic              trig;
  logic              cap_valid;
  logic [DATA_W-1:0] cap_data;
  logic              cap_ready;
  logic [9:0]        ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] pix_sample;
  logic              pix_valid;
  logic              ovf;

  modport master (
    output vidstate, h, frame_start, arm, trig, cap_valid, cap_data, ram_rdata,
    input  cap_ready, ram_addr, ram_we, ram_wdata, pix_sample, pix_valid, ovf
  );

  modport slave (
    input  vidstate, h, frame_start, arm, trig, cap_valid, cap_data, ram_rdata,
    output cap_ready, ram_addr, ram_we, ram_wdata, pix_sample, pix_valid, ovf
  );
endinterface

// File: rtl/trace_ram_arbiter.sv
// Captures a triggered ADC trace into a single-port RAM, writing only during video blanking.
// Optional: define TRACE_AUTO_REARM_EN to re-arm from HOLD on every frame_start.
module trace_ram_arbiter #(
  parameter int DEPTH      = 640,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  trace_ram_arbiter_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C      = CW'(DEPTH - 1);
  localparam logic [AW:0]   FIFO_FULL_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLD} state_t;

  state_t            state_q;
  logic [CW-1:0]     push_cnt_q;
  logic [CW-1:0]     wr_cnt_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW:0]       fifo_cnt_q;
  logic [AW:0]       fifo_cnt_d;
  logic              ovf_q;
  logic              vid_p1_q;
  logic              pix_valid_q;
  logic [DATA_W-1:0] pix_sample_q;

  logic in_cap, cap_open, fifo_full, fifo_empty;
  logic disp_gnt, wr_gnt, push_en, start_cap, flush, last_wr, auto_rearm;

  assign in_cap     = (state_q == CAPTURE);
  assign fifo_full  = (fifo_cnt_q == FIFO_FULL_C);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign cap_open   = in_cap && (push_cnt_q < DEPTH_C);

  // Display owns the RAM throughout active video; the writer drains only in blanking.
  // Reset is folded in so ram_addr reads 0 while rst is held, regardless of vidstate.
  assign disp_gnt  = bus.vidstate && rst;
  assign wr_gnt    = !bus.vidstate && in_cap && !fifo_empty;
  assign push_en   = cap_open && bus.cap_valid && bus.cap_ready;
  assign start_cap = (state_q == ARMED) && bus.trig;
  assign flush     = bus.arm || start_cap;
  assign last_wr   = wr_gnt && (wr_cnt_q == LAST_C);

`ifdef TRACE_AUTO_REARM_EN
  assign auto_rearm = (state_q == HOLD) && bus.frame_start;
`else
  logic unused_frame_start;
  assign unused_frame_start = bus.frame_start;
  assign auto_rearm         = 1'b0;
`endif

  // A pop frees a slot in the same cycle, so a full FIFO still accepts while draining.
  assign bus.cap_ready = cap_open ? (!fifo_full || wr_gnt) : 1'b1;

  assign bus.ram_addr  = disp_gnt ? bus.h : (wr_gnt ? 10'(wr_cnt_q) : 10'd0);
  assign bus.ram_we    = wr_gnt;
  assign bus.ram_wdata = wr_gnt ? fifo_mem[rd_ptr_q] : '0;

  assign bus.pix_sample = pix_sample_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.ovf        = ovf_q;

  assign fifo_cnt_d = fifo_cnt_q + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, wr_gnt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      push_cnt_q   <= '0;
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      vid_p1_q     <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_sample_q <= '0;
    end else begin
      // pixel stage: RAM read data lands one cycle after the address, registered once more
      vid_p1_q     <= bus.vidstate;
      pix_valid_q  <= vid_p1_q;
      pix_sample_q <= bus.ram_rdata;

      if (start_cap) begin
        state_q <= CAPTURE;
      end else if (bus.arm || auto_rearm) begin
        state_q <= ARMED;
      end else if (last_wr) begin
        state_q <= HOLD;
      end

      if (bus.arm || auto_rearm) begin
        ovf_q <= 1'b0;
      end else if (in_cap && bus.cap_valid && !bus.cap_ready) begin
        ovf_q <= 1'b1;
      end

      if (flush) begin
        push_cnt_q <= '0;
        wr_cnt_q   <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        fifo_cnt_q <= '0;
      end else begin
        if (push_en) begin
          push_cnt_q <= push_cnt_q + 1'b1;
          wr_ptr_q   <= wr_ptr_q + 1'b1;
        end
        if (wr_gnt) begin
          wr_cnt_q <= wr_cnt_q + 1'b1;
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        fifo_cnt_q <= fifo_cnt_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !flush) begin
      fifo_mem[wr_ptr_q] <= bus.cap_data;
    end
  end

endmodule

// File: tb/tb_trace_ram_arbiter.sv
// Randomized bench for trace_ram_arbiter against a queue-based behavioural model,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_trace_ram_arbiter;
  localparam int DEPTH      = 640;
  localparam int DATA_W     = 12;
  localparam int FIFO_DEPTH = 8;
  localparam int S_IDLE = 0, S_ARMED = 1, S_CAP = 2, S_HOLD = 3;
`ifdef TRACE_AUTO_REARM_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  trace_ram_arbiter_if #(.DATA_W(DATA_W)) bus();

  trace_ram_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Trace RAM: one-cycle read latency, read-before-write, with a bench preload port.
  logic [DATA_W-1:0] ram [1024];
  logic              pre_we   = 1'b0;
  logic [9:0]        pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int m_st = S_IDLE;
  int m_q[$];
  int m_push = 0, m_wr = 0;
  bit m_ovf = 0;
  int mram [1024];
  bit mknown [1024];
  int m_rd1 = 0;   bit m_rd1_k = 0;
  int m_pix = 0;   bit m_pix_k = 1;
  bit m_vd1 = 0, m_pv = 0;

  // Compare process: outputs for the current inputs, then advance the model to the next edge.
  initial begin : compare
    bit disp, wr, open;
    int e_rdy, e_addr, nrd;
    bit nrk;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_st = S_IDLE; m_q.delete(); m_push = 0; m_wr = 0; m_ovf = 0;
        m_pix = 0; m_pix_k = 1; m_vd1 = 0; m_pv = 0;
      end
      disp   = bus.vidstate && rst;
      wr     = !bus.vidstate && (m_st == S_CAP) && (m_q.size() > 0);
      open   = (m_st == S_CAP) && (m_push < DEPTH);
      e_rdy  = open ? ((m_q.size() < FIFO_DEPTH || wr) ? 1 : 0) : 1;
      e_addr = disp ? int'(bus.h) : (wr ? m_wr : 0);
      chk("cap_ready", bus.cap_ready, e_rdy);
      chk("ram_we", bus.ram_we, wr);
      chk("ram_addr", bus.ram_addr, e_addr);
      if (wr) chk("ram_wdata", bus.ram_wdata, m_q[0]);
      chk("pix_valid", bus.pix_valid, m_pv);
      if (m_pix_k) chk("pix_sample", bus.pix_sample, m_pix);
      chk("ovf", bus.ovf, m_ovf);

      nrd = mram[e_addr];
      nrk = mknown[e_addr];
      if (pre_we) begin
        mram[pre_addr] = int'(pre_data); mknown[pre_addr] = 1;
      end else if (wr) begin
        mram[m_wr] = m_q[0]; mknown[m_wr] = 1;
      end
      if (rst) begin
        m_pix = m_rd1; m_pix_k = m_rd1_k; m_pv = m_vd1; m_vd1 = bus.vidstate;
      end
      m_rd1 = nrd; m_rd1_k = nrk;
      if (rst) begin
        if (bus.arm) m_ovf = 0;
        else if (m_st == S_CAP && bus.cap_valid && e_rdy == 0) m_ovf = 1;
        if (wr) begin void'(m_q.pop_front()); m_wr++; end
        if (open && bus.cap_valid && e_rdy == 1) begin m_q.push_back(int'(bus.cap_data)); m_push++; end
        if (m_st == S_ARMED && bus.trig) begin
          m_st = S_CAP; m_q.delete(); m_push = 0; m_wr = 0;
        end else if (bus.arm) begin
          m_st = S_ARMED; m_q.delete(); m_push = 0; m_wr = 0;
        end else if (AUTO == 1 && m_st == S_HOLD && bus.frame_start) begin
          m_st = S_ARMED; m_ovf = 0;
        end else if (m_st == S_CAP && m_wr == DEPTH) begin
          m_st = S_HOLD;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_s [DEPTH];

  initial begin : driver
    int acc, n, hc, sent, d, we_cnt, dens;
    bus.vidstate = 0; bus.h = '0; bus.frame_start = 0; bus.arm = 0; bus.trig = 0;
    bus.cap_valid = 0; bus.cap_data = '0;
    rst = 0;

    // preload RAM[37] while in reset
    tick(); pre_we = 1; pre_addr = 10'd37; pre_data = 12'hABC;
    tick(); pre_we = 0;
    chk("reset_cap_ready", bus.cap_ready, 1);
    chk("reset_ram_we", bus.ram_we, 0);
    chk("reset_ram_addr", bus.ram_addr, 0);
    chk("reset_pix_valid", bus.pix_valid, 0);
    chk("reset_pix_sample", bus.pix_sample, 0);
    chk("reset_ovf", bus.ovf, 0);
    tick(); rst = 1;

    // display read of a preloaded location
    tick(); bus.vidstate = 1; bus.h = 10'd37;
    tick(); tick();
    chk("h37_pix_sample", bus.pix_sample, 12'hABC);
    chk("h37_pix_valid", bus.pix_valid, 1);
    chk("h37_ram_we", bus.ram_we, 0);

    // arm, then arm+trig together in ARMED; valid held high through active video
    tick(); bus.arm = 1;
    tick(); bus.arm = 0;
    tick(); bus.arm = 1; bus.trig = 1;
    tick(); bus.arm = 0; bus.trig = 0; bus.cap_valid = 1;
    acc = 0;
    for (int i = 0; i < 640; i++) begin
      bus.h = 10'(i); bus.cap_data = DATA_W'($urandom);
      #1;
      if (i == 8) begin
        chk("armtrig_pushes_by_cycle8", acc, 8);
        chk("armtrig_ready_low_when_full", bus.cap_ready, 0);
      end
      if (bus.cap_ready) acc++;
      tick();
    end
    chk("overflow_pushes", acc, 8);
    chk("overflow_ovf", bus.ovf, 1);
    chk("overflow_cap_ready", bus.cap_ready, 0);

    // reset mid-capture at push count 100
    bus.vidstate = 0; bus.cap_valid = 0;
    tick(); bus.arm = 1;
    tick(); bus.arm = 0; bus.trig = 1;
    tick(); bus.trig = 0; bus.cap_valid = 1;
    n = 0;
    while (m_push < 100 && n < 1000) begin
      bus.cap_data = DATA_W'($urandom);
      tick(); n++;
    end
    chk("midcap_push100_reached", (m_push == 100) ? 1 : 0, 1);
    rst = 0; bus.vidstate = 1; bus.h = 10'd55;
    #1;
    chk("midcap_rst_cap_ready", bus.cap_ready, 1);
    chk("midcap_rst_ram_we", bus.ram_we, 0);
    chk("midcap_rst_ram_addr", bus.ram_addr, 0);
    chk("midcap_rst_pix_sample", bus.pix_sample, 0);
    chk("midcap_rst_pix_valid", bus.pix_valid, 0);
    chk("midcap_rst_ovf", bus.ovf, 0);
    tick(); rst = 1; bus.vidstate = 0; bus.cap_valid = 0;

    // full capture: samples every 4 cycles, 800-cycle lines with 640 active
    tick(); bus.arm = 1;
    tick(); bus.arm = 0; bus.trig = 1;
    tick(); bus.trig = 0;
    hc = 0; sent = 0; n = 0;
    while (m_st != S_HOLD && n < 30000) begin
      bus.vidstate = (hc < 640);
      bus.h = (hc < 640) ? 10'(hc) : 10'd0;
      bus.cap_valid = 0;
      if (sent < DEPTH && (n % 4) == 0) begin
        #1;
        if (bus.cap_ready) begin
          d = $urandom_range(0, 4095);
          bus.cap_data = DATA_W'(d); bus.cap_valid = 1;
          exp_s[sent] = d; sent++;
        end
      end
      tick();
      hc = (hc == 799) ? 0 : hc + 1;
      n++;
    end
    bus.vidstate = 0; bus.cap_valid = 0;
    tick();
    chk("capture_hold_reached", (m_st == S_HOLD) ? 1 : 0, 1);
    chk("capture_samples_sent", sent, DEPTH);
    chk("capture_ovf", bus.ovf, 0);
    for (int k = 0; k < DEPTH; k++) chk("capture_ram_k", ram[k], exp_s[k]);

    // trig ignored in HOLD
    tick(); bus.trig = 1;
    tick(); bus.trig = 0; bus.cap_valid = 1;
    we_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.cap_data = DATA_W'($urandom); tick();
      if (bus.ram_we) we_cnt++;
    end
    chk("hold_trig_no_writes", we_cnt, 0);

    // frame_start in HOLD: re-arms only with auto re-arm
    bus.cap_valid = 0; bus.frame_start = 1;
    tick(); bus.frame_start = 0;
    tick(); bus.trig = 1;
    tick(); bus.trig = 0; bus.cap_valid = 1;
    we_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.cap_data = DATA_W'($urandom); tick();
      if (bus.ram_we) we_cnt++;
    end
    chk("frame_start_rearm", (we_cnt > 0) ? 1 : 0, AUTO);

    // randomized traffic
    hc = 0; dens = 5;
    for (int i = 0; i < 15000; i++) begin
      if (hc == 0) dens = $urandom_range(1, 10);
      rst = ($urandom_range(0, 4999) != 0);
      bus.vidstate    = (hc < 640);
      bus.h           = (hc < 640) ? 10'(hc) : 10'($urandom);
      bus.arm         = ($urandom_range(0, 2999) == 0);
      bus.trig        = ($urandom_range(0, 39) == 0);
      bus.frame_start = (hc == 700) && ($urandom_range(0, 1) == 1);
      bus.cap_valid   = ($urandom_range(1, 10) <= dens);
      bus.cap_data    = DATA_W'($urandom);
      tick();
      hc = (hc == 799) ? 0 : hc + 1;
    end
    rst = 1; bus.arm = 0; bus.trig = 0; bus.frame_start = 0; bus.cap_valid = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_ram_arbiter.md
TRACE_RAM_ARBITER -- requirements
Module: trace_ram_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 640, trace samples per capture (one per visible column).
REQ-002 SHALL have parameter DATA_W, default 12, sample width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, capture FIFO entries (power of two).
REQ-004 SHALL have port clk  in  1  sole clock (VGA pixel clock).
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port vidstate  in  1  high during active video, from VGA sync.
REQ-007 SHALL have port h  in  10  current pixel column, valid when vidstate=1.
REQ-008 SHALL have port frame_start  in  1  one-cycle pulse at start of each frame.
REQ-009 SHALL have port arm  in  1  one-cycle pulse: (re)arm capture.
REQ-010 SHALL have port trig  in  1  one-cycle trigger pulse.
REQ-011 SHALL have port cap_valid  in  1  ADC sample present.
REQ-012 SHALL have port cap_data  in  DATA_W  ADC sample.
REQ-013 SHALL have port cap_ready  out  1  sample accepted when cap_valid&cap_ready.
REQ-014 SHALL have port ram_addr  out  10  single-port trace RAM address.
REQ-015 SHALL have port ram_we  out  1  RAM write enable.
REQ-016 SHALL have port ram_wdata  out  DATA_W  RAM write data.
REQ-017 SHALL have port ram_rdata  in  DATA_W  RAM read data, valid one cycle after address.
REQ-018 SHALL have port pix_sample  out  DATA_W  trace sample for current pixel pipeline.
REQ-019 SHALL have port pix_valid  out  1  pix_sample valid.
REQ-020 SHALL have port ovf  out  1  sticky overflow flag.

Function
REQ-021 SHALL implement states IDLE, ARMED, CAPTURE, HOLD.
REQ-022 SHALL transition IDLE->ARMED on arm; ARMED->CAPTURE on trig; CAPTURE->HOLD when write count reaches DEPTH; HOLD->ARMED on arm; any state except IDLE ->ARMED on arm.
REQ-023 SHALL ignore trig outside ARMED; arm and trig same cycle in ARMED SHALL enter CAPTURE.
REQ-024 SHALL on entering CAPTURE clear push count, write count (RAM address) and FIFO.
REQ-025 SHALL in IDLE, ARMED, HOLD drive cap_ready=1 and discard samples.
REQ-026 SHALL in CAPTURE, while push count < DEPTH, drive cap_ready=!fifo_full and push accepted samples; push count SHALL increment per push.
REQ-027 SHALL in CAPTURE, once push count = DEPTH, drive cap_ready=1 and discard samples without setting ovf.
REQ-028 SHALL set ovf when in CAPTURE with cap_valid=1, cap_ready=0; ovf cleared only by arm or reset.
REQ-029 SHALL grant RAM to display whenever vidstate=1: ram_addr=h, ram_we=0, combinationally same cycle.
REQ-030 SHALL grant RAM to writer when vidstate=0, state=CAPTURE, FIFO non-empty: ram_addr=write count, ram_we=1, ram_wdata=FIFO head, pop FIFO, increment write count.
REQ-031 SHALL drive ram_we=0, ram_addr=0 when neither grant applies; display and write SHALL never be granted in the same cycle.
REQ-032 SHALL register pix_sample<=ram_rdata and pix_valid<=vidstate delayed one cycle, so data for a read in cycle n appears in cycle n+2 with pix_valid=1.
REQ-033 SHALL wrap addresses never: write count max DEPTH-1, then HOLD the cycle after the DEPTH-th write.
REQ-034 SHALL on arm during CAPTURE abort capture, flush FIFO, keep RAM contents, enter ARMED.
REQ-035 SHALL accept a push and a pop in the same cycle on a full FIFO without loss.

Reset
REQ-036 SHALL on rst=0 asynchronously force: state IDLE, counts 0, FIFO empty, ovf 0, ram_we 0, ram_addr 0, pix_sample 0, pix_valid 0; cap_ready 1.
REQ-037 SHALL leave RAM contents untouched by reset.

Configuration
REQ-038 SHALL, when TRACE_AUTO_REARM_EN is defined, additionally transition HOLD->ARMED on frame_start (clearing ovf); without it HOLD exits only on arm.

Verification
REQ-039 Reset mid-CAPTURE at push count 100 -> all outputs at REQ-036 values same cycle, state IDLE.
REQ-040 arm, trig, 640 samples one per 4 cycles, 800-cycle lines with 640 active -> RAM addr k holds sample k, HOLD reached, ovf=0.
REQ-041 vidstate=1, h=37, RAM[37]=0xABC -> pix_sample=0xABC, pix_valid=1 two cycles later; ram_we=0 throughout active video.
REQ-042 CAPTURE, cap_valid held high through 640 active cycles with FIFO_DEPTH=8 -> 8 pushes, cap_ready=0 after, ovf=1.
REQ-043 arm and trig same cycle in ARMED -> CAPTURE next cycle; trig in HOLD -> stays HOLD.
REQ-044 HOLD then frame_start -> ARMED with TRACE_AUTO_REARM_EN defined, remains HOLD without it.
